// File: rtl/forth_pkg.sv
// Shared types and constants for the forth core memory responder.
package forth_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned DADR_W = 8;
  // Header word count is a full 16-bit field so oversized images can be detected.
  localparam int unsigned CNT_W  = 16;

  typedef logic [WORD_W-1:0] idata_t;
  typedef logic [DADR_W-1:0] daddr_t;

  // Word returned for unloaded or inaccessible instruction addresses.
  localparam idata_t NOP_WORD = 16'he040;

  typedef enum logic [2:0] {
    HDR_LO = 3'd0,
    HDR_HI = 3'd1,
    W_LO   = 3'd2,
    W_HI   = 3'd3,
    RUN    = 3'd4,
    ERR    = 3'd5
  } load_state_t;

endpackage

// File: rtl/forth_loader.sv
// Byte-stream program loader: header word count, then little-endian words into imem.
module forth_loader
  import forth_pkg::*;
#(
  parameter int unsigned IADDR_W = 10,
  parameter int unsigned DATA_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  input  logic               reload,
  output load_state_t        state,
  output logic [CNT_W-1:0]   count,
  output logic               imem_we_c,
  output logic [IADDR_W-1:0] imem_waddr,
  output logic [DATA_W-1:0]  imem_wdata_c
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(2**IADDR_W);

  load_state_t        state_nxt;
  logic [CNT_W-1:0]   count_nxt;
  logic [IADDR_W-1:0] waddr_nxt;
  logic [7:0]         lo, lo_nxt;
  logic [CNT_W-1:0]   hdr_count_c;
  logic               loading_c;
  logic               accept_c;

  assign loading_c   = (state == HDR_LO) || (state == HDR_HI) ||
                       (state == W_LO)   || (state == W_HI);
  assign accept_c    = rx_valid && loading_c;
  assign hdr_count_c = CNT_W'({rx_data, lo});

  // Loader state and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= HDR_LO;
      count      <= '0;
      imem_waddr <= '0;
      lo         <= '0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      imem_waddr <= waddr_nxt;
      lo         <= lo_nxt;
    end
  end

  // Next-state, counter update and imem write strobe; reload wins over a same-cycle byte.
  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    waddr_nxt    = imem_waddr;
    lo_nxt       = lo;
    imem_we_c    = 1'b0;
    imem_wdata_c = DATA_W'({rx_data, lo});
    if (reload) begin
      state_nxt = HDR_LO;
      count_nxt = '0;
      waddr_nxt = '0;
    end else if (accept_c) begin
      case (state)
        HDR_LO: begin
          lo_nxt    = rx_data;
          state_nxt = HDR_HI;
        end
        HDR_HI: begin
          count_nxt = hdr_count_c;
          if (hdr_count_c == '0)          state_nxt = RUN;
          else if (hdr_count_c > MAX_CNT) state_nxt = ERR;
          else                            state_nxt = W_LO;
        end
        W_LO: begin
          lo_nxt    = rx_data;
          state_nxt = W_HI;
        end
        W_HI: begin
          imem_we_c = 1'b1;
          waddr_nxt = imem_waddr + IADDR_W'(1);
          if (CNT_W'(imem_waddr) == count - CNT_W'(1)) state_nxt = RUN;
          else                                          state_nxt = W_LO;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/forth_mem.sv
// Instruction and data memory for the forth core, with boot-time program loader.
module forth_mem
  import forth_pkg::*;
#(
  parameter int unsigned IADDR_W = 10,
  parameter int unsigned DADDR_W = 8,
  parameter int unsigned DATA_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0]  idata,
  input  logic [DADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0]  ddata_write,
  input  logic               dwrite,
  output logic [DATA_W-1:0]  ddata_read,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  input  logic               reload,
  output logic               cpu_reset,
  output logic               load_err
);

  localparam int unsigned IDEPTH = 2**IADDR_W;
  localparam int unsigned DDEPTH = 2**DADDR_W;

  logic [DATA_W-1:0]  imem [IDEPTH];
  logic [DATA_W-1:0]  dmem [DDEPTH];

  load_state_t        state;
  logic [CNT_W-1:0]   count;
  logic               imem_we_c;
  logic [IADDR_W-1:0] imem_waddr;
  logic [DATA_W-1:0]  imem_wdata_c;
  logic               run_c;

  forth_loader #(
    .IADDR_W (IADDR_W),
    .DATA_W  (DATA_W)
  ) u_loader (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .reload       (reload),
    .state        (state),
    .count        (count),
    .imem_we_c    (imem_we_c),
    .imem_waddr   (imem_waddr),
    .imem_wdata_c (imem_wdata_c)
  );

  // Status decoded straight from the loader state register.
  assign run_c     = (state == RUN);
  assign cpu_reset = !run_c;
  assign load_err  = (state == ERR);
  assign rx_ready  = !run_c && (state != ERR);

  // Instruction RAM write port, driven only by the loader.
  always_ff @(posedge clk) begin
    if (imem_we_c) imem[imem_waddr] <= imem_wdata_c;
  end

  // Instruction fetch; anything outside the loaded image reads as NOP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               idata <= DATA_W'(NOP_WORD);
    else if (run_c && (CNT_W'(iaddr) < count)) idata <= imem[iaddr];
    else                                     idata <= DATA_W'(NOP_WORD);
  end

  // Data RAM write port, live only while the core runs.
  always_ff @(posedge clk) begin
    if (run_c && dwrite) dmem[daddr] <= ddata_write;
  end

  // Data read, read-first against a same-address write; holds outside RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      ddata_read <= '0;
    else if (run_c) ddata_read <= dmem[daddr];
  end

endmodule

// File: tb/tb_forth_mem.sv
// Self-checking bench for forth_mem: loader sequences, fetch and data-port vectors.
module tb_forth_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  iaddr;
  logic [15:0] idata;
  logic [7:0]  daddr;
  logic [15:0] ddata_write;
  logic        dwrite;
  logic [15:0] ddata_read;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        reload;
  logic        cpu_reset;
  logic        load_err;

  int total  = 0;
  int passed = 0;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [9:0]  iaddr;
    logic [15:0] exp;
  } fvec_t;

  typedef struct {
    logic [7:0]  daddr;
    logic [15:0] wdata;
    logic        we;
    logic        chk;
    logic [15:0] exp;
  } dvec_t;

  forth_mem dut (
    .clk         (clk),
    .reset       (reset),
    .iaddr       (iaddr),
    .idata       (idata),
    .daddr       (daddr),
    .ddata_write (ddata_write),
    .dwrite      (dwrite),
    .ddata_read  (ddata_read),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .reload      (reload),
    .cpu_reset   (cpu_reset),
    .load_err    (load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte after 'gap' idle cycles; loader is expected to be ready.
  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) tick();
    rx_data  = b;
    rx_valid = 1'b1;
    chk("rx_ready_on_send", {15'd0, rx_ready}, 16'd1);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int gap);
    send_byte(w[7:0], gap);
    send_byte(w[15:8], gap);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  // Fetch through the scoreboard: expectation queued at drive, checked one cycle later.
  task automatic fetch(input string name, input logic [9:0] a, input logic [15:0] exp);
    sb_t e;
    iaddr  = a;
    e.name = name;
    e.exp  = exp;
    sb.push_back(e);
    tick();
    e = sb.pop_front();
    chk(e.name, idata, e.exp);
  endtask

  function automatic logic [15:0] big_word(input int i);
    return 16'(i) ^ 16'ha5c3;
  endfunction

  initial begin
    fvec_t fv[3];
    dvec_t dv[7];
    sb_t   e;
    logic [15:0] held;

    fv[0] = '{iaddr: 10'd0, exp: 16'h0001};
    fv[1] = '{iaddr: 10'd1, exp: 16'he007};
    fv[2] = '{iaddr: 10'd2, exp: 16'he040};

    dv[0] = '{daddr: 8'h05, wdata: 16'h0000, we: 1'b1, chk: 1'b0, exp: 16'h0000};
    dv[1] = '{daddr: 8'h09, wdata: 16'h1357, we: 1'b1, chk: 1'b0, exp: 16'h0000};
    dv[2] = '{daddr: 8'h05, wdata: 16'hbeef, we: 1'b1, chk: 1'b1, exp: 16'h0000};
    dv[3] = '{daddr: 8'h05, wdata: 16'h0000, we: 1'b0, chk: 1'b1, exp: 16'hbeef};
    dv[4] = '{daddr: 8'h09, wdata: 16'h0000, we: 1'b0, chk: 1'b1, exp: 16'h1357};
    dv[5] = '{daddr: 8'h09, wdata: 16'h2468, we: 1'b1, chk: 1'b1, exp: 16'h1357};
    dv[6] = '{daddr: 8'h09, wdata: 16'h0000, we: 1'b0, chk: 1'b1, exp: 16'h2468};

    reset = 1'b1; iaddr = '0; daddr = '0; ddata_write = '0; dwrite = 1'b0;
    rx_data = '0; rx_valid = 1'b0; reload = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_idata",     idata,               16'he040);
    chk("rst_ddata",     ddata_read,          16'h0000);
    chk("rst_cpu_reset", {15'd0, cpu_reset},  16'd1);
    chk("rst_load_err",  {15'd0, load_err},   16'd0);
    chk("rst_rx_ready",  {15'd0, rx_ready},   16'd1);
    reset = 1'b0;
    tick();

    // Two-word image: release on sixth byte, then fetch vectors.
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h07, 0);
    chk("t1_cpu_reset_before_last", {15'd0, cpu_reset}, 16'd1);
    send_byte(8'he0, 0);
    chk("t1_cpu_reset_after_last", {15'd0, cpu_reset}, 16'd0);
    chk("t1_rx_ready_run",         {15'd0, rx_ready},  16'd0);
    for (int i = 0; i < 3; i++) fetch($sformatf("t1_fetch%0d", i), fv[i].iaddr, fv[i].exp);

    // Empty image: straight to RUN, every fetch is NOP.
    pulse_reload();
    chk("t2_reload_cpu_reset", {15'd0, cpu_reset}, 16'd1);
    chk("t2_reload_rx_ready",  {15'd0, rx_ready},  16'd1);
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    chk("t2_cpu_reset", {15'd0, cpu_reset}, 16'd0);
    chk("t2_rx_ready",  {15'd0, rx_ready},  16'd0);
    fetch("t2_fetch0", 10'd0, 16'he040);
    fetch("t2_fetch1", 10'd1, 16'he040);

    // Oversized header 1025 -> error, cleared by reload.
    pulse_reload();
    send_byte(8'h01, 0); send_byte(8'h04, 0);
    chk("t3_load_err",  {15'd0, load_err},  16'd1);
    chk("t3_cpu_reset", {15'd0, cpu_reset}, 16'd1);
    chk("t3_rx_ready",  {15'd0, rx_ready},  16'd0);
    fetch("t3_fetch0", 10'd0, 16'he040);
    pulse_reload();
    chk("t3_clr_load_err", {15'd0, load_err}, 16'd0);
    chk("t3_clr_rx_ready", {15'd0, rx_ready}, 16'd1);

    // Three-word image with random byte gaps.
    send_byte(8'h03, $urandom_range(0, 5)); send_byte(8'h00, $urandom_range(0, 5));
    send_word(16'h1111, $urandom_range(0, 5));
    send_word(16'h2222, $urandom_range(0, 5));
    send_byte(8'h33, $urandom_range(0, 5));
    repeat ($urandom_range(0, 5)) tick();
    chk("t6_cpu_reset_stall", {15'd0, cpu_reset}, 16'd1);
    send_byte(8'h33, $urandom_range(0, 5));
    chk("t6_cpu_reset_release", {15'd0, cpu_reset}, 16'd0);
    fetch("t6_fetch0", 10'd0, 16'h1111);
    fetch("t6_fetch1", 10'd1, 16'h2222);
    fetch("t6_fetch2", 10'd2, 16'h3333);
    fetch("t6_fetch3", 10'd3, 16'he040);

    // Data port vectors through the scoreboard.
    for (int i = 0; i < 7; i++) begin
      daddr = dv[i].daddr; ddata_write = dv[i].wdata; dwrite = dv[i].we;
      if (dv[i].chk) begin
        e.name = $sformatf("t4_data%0d", i);
        e.exp  = dv[i].exp;
        sb.push_back(e);
      end
      tick();
      if (dv[i].chk) begin
        e = sb.pop_front();
        chk(e.name, ddata_read, e.exp);
      end
    end
    dwrite = 1'b0;

    // Outside RUN writes are ignored and the read register holds.
    daddr = 8'h05;
    pulse_reload();
    held = ddata_read;
    chk("t4_reload_edge_read", held, 16'hbeef);
    daddr = 8'h09; ddata_write = 16'hffff; dwrite = 1'b1;
    tick(); tick();
    dwrite = 1'b0;
    chk("t4_hold_outside_run", ddata_read, 16'hbeef);

    // Reload in the middle of a load discards the same-cycle byte.
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    rx_data = 8'h99; rx_valid = 1'b1; reload = 1'b1;
    tick();
    rx_valid = 1'b0; reload = 1'b0;
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_word(16'habcd, 0);
    chk("t7_cpu_reset", {15'd0, cpu_reset}, 16'd0);
    fetch("t7_fetch0", 10'd0, 16'habcd);
    fetch("t7_fetch1", 10'd1, 16'he040);

    // Back in RUN the earlier ignored write must not have landed.
    daddr = 8'h09;
    tick();
    chk("t4_ignored_write", ddata_read, 16'h2468);

    // Async reset after three bytes, then a clean one-word image.
    pulse_reload();
    send_byte(8'h05, 0); send_byte(8'h00, 0); send_byte(8'haa, 0);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_cpu_reset", {15'd0, cpu_reset}, 16'd1);
    chk("t5_rst_idata",     idata,              16'he040);
    chk("t5_rst_ddata",     ddata_read,         16'h0000);
    tick();
    reset = 1'b0;
    tick();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_word(16'h1234, 0);
    chk("t5_cpu_reset", {15'd0, cpu_reset}, 16'd0);
    fetch("t5_fetch0", 10'd0, 16'h1234);
    fetch("t5_fetch1", 10'd1, 16'he040);

    // Full-depth image of 1024 words; last word lands at 1023.
    pulse_reload();
    send_byte(8'h00, 0); send_byte(8'h04, 0);
    chk("t8_not_err", {15'd0, load_err}, 16'd0);
    for (int i = 0; i < 1023; i++) send_word(big_word(i), 0);
    send_byte(big_word(1023) & 16'h00ff, 0);
    chk("t8_cpu_reset_before_last", {15'd0, cpu_reset}, 16'd1);
    send_byte(8'(big_word(1023) >> 8), 0);
    chk("t8_cpu_reset_after_last", {15'd0, cpu_reset}, 16'd0);
    fetch("t8_fetch0",    10'd0,    big_word(0));
    fetch("t8_fetch511",  10'd511,  big_word(511));
    fetch("t8_fetch1023", 10'd1023, big_word(1023));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/forth_mem.md
Name: forth_mem

Overview:
- Memory responder for the forth core. It serves the core's instruction-fetch port (iaddr/idata) and data port (daddr/ddata_write/ddata_read/dwrite).
- At boot it loads the program image from a byte stream into instruction RAM. It holds the core in reset until the load completes.
- It sits between the forth core and the board-level serial/byte source.

Parameters:
- IADDR_W, 10, instruction address width; instruction RAM depth is 2**IADDR_W words.
- DADDR_W, 8, data address width; data RAM depth is 2**DADDR_W words.
- DATA_W, 16, word width for instructions and data.
- NOP_WORD, 16'he040, word returned for unloaded or inaccessible instruction addresses.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- iaddr  in  IADDR_W  instruction fetch address from core.
- idata  out  DATA_W  registered instruction word.
- daddr  in  DADDR_W  data address from core.
- ddata_write  in  DATA_W  data write value.
- dwrite  in  1  data write strobe.
- ddata_read  out  DATA_W  registered data read value.
- rx_data  in  8  loader byte.
- rx_valid  in  1  loader byte valid.
- rx_ready  out  1  loader accepts byte; transfer occurs when rx_valid and rx_ready are both high at a clock edge.
- reload  in  1  single-cycle request to reload the program.
- cpu_reset  out  1  reset to the forth core.
- load_err  out  1  image header invalid.

Behaviour:
- Reset values: state HDR_LO, count 0, idata NOP_WORD, ddata_read 0, cpu_reset 1, load_err 0, rx_ready 1.
- Loader FSM states and transitions:
  - HDR_LO -> HDR_HI: captures the low byte of the word count.
  - HDR_HI: captures the high byte of the word count.
    - count == 0 -> RUN.
    - count > 2**IADDR_W -> ERR.
    - otherwise -> W_LO.
  - W_LO -> W_HI: captures the low byte of the next word.
  - W_HI: writes {hi, lo} to imem[waddr] and increments waddr. After the last word (waddr == count-1) -> RUN, else -> W_LO.
  - RUN: stays in RUN. reload -> HDR_LO, with waddr and count cleared.
  - ERR: stays in ERR. reload -> HDR_LO.
- States advance only on an accepted byte (rx_valid & rx_ready). An idle rx_valid stalls indefinitely with no timeout.
- rx_ready = 1 in HDR_LO/HDR_HI/W_LO/W_HI, 0 in RUN and ERR.
- cpu_reset = (state != RUN), decoded directly from the state register.
  - Falls on the edge that accepts the final byte.
  - Rises on the edge that samples reload.
- load_err = (state == ERR).
- Instruction port, 1-cycle latency:
  - idata <= imem[iaddr] if state == RUN and iaddr < count, else NOP_WORD.
  - Addresses beyond the loaded image return NOP_WORD; imem is never cleared.
- Data port, 1-cycle latency:
  - In RUN with dwrite = 1: dmem[daddr] <= ddata_write.
  - ddata_read <= dmem[daddr] every cycle, read-first: a read-during-write to the same address returns the old value.
  - Outside RUN, dwrite is ignored and ddata_read holds its value.
- Count boundary: count == 2**IADDR_W is legal; the last word goes to address 2**IADDR_W-1 and waddr wraps to 0 without effect.
- reload while already in HDR_LO..W_HI: restarts at HDR_LO with count 0. A byte accepted in the same cycle is discarded.
- Asynchronous reset mid-load: immediately returns to the reset values above. RAM contents are undefined but unreachable until reloaded.

Decomposition:
- forth_pkg holds:
  - NOP_WORD constant.
  - load_state_t enum {HDR_LO, HDR_HI, W_LO, W_HI, RUN, ERR}.
  - idata_t/daddr_t word typedefs shared with the core.
- Sub-module forth_loader contains the byte-stream FSM, count/waddr registers and imem write port.
- forth_mem instantiates forth_loader and owns both RAM arrays and the read registers.

Test Plan:
- Stream 02 00 01 00 07 e0, then fetch iaddr 0,1,2 -> cpu_reset falls on the 6th accepted byte; idata = 0001, e007, e040 on successive cycles.
- Header 00 00 -> RUN after 2 bytes; any iaddr returns e040; rx_ready = 0.
- Header 01 04 (count 1025) -> load_err = 1, cpu_reset stays 1, rx_ready = 0. Pulse reload -> load_err = 0, rx_ready = 1.
- In RUN: dwrite daddr 05 = beef, next cycle read daddr 05 -> ddata_read = beef. A simultaneous read at the write cycle returns the prior value 0000 (after the first write from reset-known data).
- Assert reset after 3 bytes, then stream a full 1-word image 01 00 34 12 -> idata at iaddr 0 = 1234; the stale partial load has no effect.
- Toggle rx_valid with gaps of 0-5 idle cycles during the load -> identical imem contents and cpu_reset release on the final accepted byte.
